// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 104;
  localparam int unsigned DEF_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous input pins; RESET_VAL should match the pin's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: mid-bit sampling, framing/overrun detection,
// single-entry holding register on a valid/ready handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEF_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 i_reset_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q;

  logic rx_s;
  logic cnt_last_c;
  logic cnt_mid_c;
  logic stop_sample_c;
  logic deliver_c;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clock     (clock),
    .i_reset_n (i_reset_n),
    .i_async   (i_rx),
    .o_sync    (rx_s)
  );

  assign cnt_last_c    = (cnt_q == CNT_LAST);
  assign cnt_mid_c     = (cnt_q == CNT_MID);
  assign stop_sample_c = (state_q == STOP) && cnt_last_c;
  assign deliver_c     = stop_sample_c && rx_s;

  // State register
  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rx_s) state_d = START;
      START:   if (cnt_mid_c) state_d = rx_s ? IDLE : DATA;
      DATA:    if (cnt_last_c && (idx_q == IDX_LAST)) state_d = STOP;
      STOP:    if (cnt_last_c) state_d = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, shifter and holding-register next values
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = stop_sample_c && !rx_s;
    ovr_d   = 1'b0;

    case (state_q)
      START: begin
        cnt_d = cnt_mid_c ? '0 : cnt_q + CNT_W'(1);
        idx_d = '0;
      end
      DATA: begin
        if (cnt_last_c) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q != IDX_LAST) idx_d = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP:    cnt_d = cnt_last_c ? '0 : cnt_q + CNT_W'(1);
      default: cnt_d = '0;
    endcase

    // A byte arriving while the consumer accepts the old one is a legal reload.
    if (deliver_c) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 8 clocks/bit, one at 5 clocks/bit.
module tb_uart_rx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst_n;
  logic       rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       val_a, val_b, ferr_a, ferr_b, ovr_a, ovr_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  int rise_a, vcyc_a, fall_a, ferr_cnt_a, ferr_edge_a, ovr_cnt_a, ovr_edge_a;
  int fall_b, ferr_cnt_b, ovr_cnt_b, both_cnt;
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;

  uart_rx #(.CLKS_PER_BIT(8), .DATA_BITS(8)) dut_a (
    .clock       (clock),
    .i_reset_n   (rst_n),
    .i_rx        (rx_a),
    .o_data      (data_a),
    .o_valid     (val_a),
    .i_ready     (rdy_a),
    .o_frame_err (ferr_a),
    .o_overrun   (ovr_a),
    .o_busy      (busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(5), .DATA_BITS(8)) dut_b (
    .clock       (clock),
    .i_reset_n   (rst_n),
    .i_rx        (rx_b),
    .o_data      (data_b),
    .o_valid     (val_b),
    .i_ready     (rdy_b),
    .o_frame_err (ferr_b),
    .o_overrun   (ovr_b),
    .o_busy      (busy_b)
  );

  // Edge counter and pulse/level event log, sampled 1 time unit after each edge.
  always begin
    @(posedge clock);
    edge_n = edge_n + 1;
    #1;
    if (val_a === 1'b1 && pv_a === 1'b0) rise_a = edge_n;
    if (val_a === 1'b0 && pv_a === 1'b1) fall_a = fall_a + 1;
    if (val_a === 1'b1) vcyc_a = vcyc_a + 1;
    if (ferr_a === 1'b1) begin ferr_cnt_a = ferr_cnt_a + 1; ferr_edge_a = edge_n; end
    if (ovr_a === 1'b1) begin ovr_cnt_a = ovr_cnt_a + 1; ovr_edge_a = edge_n; end
    if ((ferr_a === 1'b1 && ovr_a === 1'b1) || (ferr_b === 1'b1 && ovr_b === 1'b1)) both_cnt = both_cnt + 1;
    if (val_b === 1'b0 && pv_b === 1'b1) fall_b = fall_b + 1;
    if (ferr_b === 1'b1) ferr_cnt_b = ferr_cnt_b + 1;
    if (ovr_b === 1'b1) ovr_cnt_b = ovr_cnt_b + 1;
    pv_a = val_a;
    pv_b = val_b;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    rise_a = -1; vcyc_a = 0; fall_a = 0; ferr_cnt_a = 0; ferr_edge_a = -1;
    ovr_cnt_a = 0; ovr_edge_a = -1; fall_b = 0; ferr_cnt_b = 0; ovr_cnt_b = 0;
  endtask

  // Advance n edges; always returns 2 time units after an edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // Drive one frame; t0 is the edge that captures the start bit.
  // With rdy_pulse, ready is high only for the stop-sample edge.
  task automatic send_frame(input bit sel, input int cpb, input logic [7:0] b,
                            input logic stop_bit, input bit rdy_pulse, output int t0);
    logic [9:0] bits;
    int h;
    bits = {stop_bit, b, 1'b0};
    h = cpb / 2;
    t0 = edge_n + 1;
    for (int i = 0; i < 10; i++) begin
      if (sel) rx_b = bits[i]; else rx_a = bits[i];
      for (int j = 1; j <= cpb; j++) begin
        @(posedge clock);
        #2;
        if (rdy_pulse && i == 9 && j == h + 2) begin if (sel) rdy_b = 1'b1; else rdy_a = 1'b1; end
        if (rdy_pulse && i == 9 && j == h + 3) begin if (sel) rdy_b = 1'b0; else rdy_a = 1'b0; end
      end
    end
  endtask

  task automatic test_reset();
    cycles(3);
    n_cmp++; if (data_a !== 8'h00 || data_b !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h/%h want 00/00", data_a, data_b); end
    n_cmp++; if (val_a !== 1'b0 || val_b !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b/%b want 0/0", val_a, val_b); end
    n_cmp++; if ({ferr_a, ovr_a, busy_a, ferr_b, ovr_b, busy_b} !== 6'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 000000", {ferr_a, ovr_a, busy_a, ferr_b, ovr_b, busy_b}); end
    rst_n = 1'b1;
    cycles(2);
    clear_mon();
  endtask

  task automatic test_basic();
    int t0;
    rdy_a = 1'b1;
    clear_mon();
    send_frame(1'b0, 8, 8'hA5, 1'b1, 1'b0, t0);
    cycles(20);
    n_cmp++; if (rise_a !== t0 + 78) begin n_bad++; $display("FAIL basic_latency: got edge %0d want %0d", rise_a, t0 + 78); end
    n_cmp++; if (vcyc_a !== 1) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d want 1", vcyc_a); end
    n_cmp++; if (data_a !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h want a5", data_a); end
    n_cmp++; if (ferr_cnt_a !== 0 || ovr_cnt_a !== 0) begin n_bad++; $display("FAIL basic_errors: got ferr=%0d ovr=%0d want 0/0", ferr_cnt_a, ovr_cnt_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_overrun();
    int t0a, t0b;
    rdy_a = 1'b0;
    clear_mon();
    send_frame(1'b0, 8, 8'h3C, 1'b1, 1'b0, t0a);
    send_frame(1'b0, 8, 8'hC3, 1'b1, 1'b0, t0b);
    cycles(5);
    n_cmp++; if (rise_a !== t0a + 78) begin n_bad++; $display("FAIL ovr_first_edge: got %0d want %0d", rise_a, t0a + 78); end
    n_cmp++; if (val_a !== 1'b1 || data_a !== 8'h3C) begin n_bad++; $display("FAIL ovr_held: got v=%b d=%h want v=1 d=3c", val_a, data_a); end
    n_cmp++; if (ovr_cnt_a !== 1) begin n_bad++; $display("FAIL ovr_count: got %0d want 1", ovr_cnt_a); end
    n_cmp++; if (ovr_edge_a !== t0b + 78) begin n_bad++; $display("FAIL ovr_edge: got %0d want %0d", ovr_edge_a, t0b + 78); end
    n_cmp++; if (fall_a !== 0 || ferr_cnt_a !== 0) begin n_bad++; $display("FAIL ovr_side: got fall=%0d ferr=%0d want 0/0", fall_a, ferr_cnt_a); end
    rdy_a = 1'b1;
    cycles(1);
    n_cmp++; if (val_a !== 1'b0 || data_a !== 8'h3C) begin n_bad++; $display("FAIL ovr_accept: got v=%b d=%h want v=0 d=3c", val_a, data_a); end
  endtask

  task automatic test_frame_err();
    int t0, t1;
    rdy_a = 1'b1;
    clear_mon();
    send_frame(1'b0, 8, 8'h55, 1'b0, 1'b0, t0);
    cycles(20);
    n_cmp++; if (ferr_cnt_a !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt_a); end
    n_cmp++; if (ferr_edge_a !== t0 + 78) begin n_bad++; $display("FAIL ferr_edge: got %0d want %0d", ferr_edge_a, t0 + 78); end
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL ferr_busy_low_line: got %b want 1", busy_a); end
    n_cmp++; if (vcyc_a !== 0 || ovr_cnt_a !== 0) begin n_bad++; $display("FAIL ferr_no_byte: got vcyc=%0d ovr=%0d want 0/0", vcyc_a, ovr_cnt_a); end
    rx_a = 1'b1;
    cycles(5);
    n_cmp++; if (busy_a !== 1'b0 || ferr_cnt_a !== 1) begin n_bad++; $display("FAIL ferr_release: got busy=%b ferr=%0d want 0/1", busy_a, ferr_cnt_a); end
    send_frame(1'b0, 8, 8'h0F, 1'b1, 1'b0, t1);
    cycles(20);
    n_cmp++; if (data_a !== 8'h0F || vcyc_a !== 1) begin n_bad++; $display("FAIL ferr_recover: got d=%h vcyc=%0d want 0f/1", data_a, vcyc_a); end
    n_cmp++; if (rise_a !== t1 + 78) begin n_bad++; $display("FAIL ferr_recover_edge: got %0d want %0d", rise_a, t1 + 78); end
  endtask

  task automatic test_glitch();
    int t0;
    clear_mon();
    rx_a = 1'b0;
    cycles(2);
    rx_a = 1'b1;
    cycles(3);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL glitch_start_seen: got busy=%b want 1", busy_a); end
    cycles(10);
    n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got busy=%b want 0", busy_a); end
    n_cmp++; if (vcyc_a !== 0 || ferr_cnt_a !== 0 || ovr_cnt_a !== 0) begin n_bad++; $display("FAIL glitch_quiet: got vcyc=%0d ferr=%0d ovr=%0d want 0/0/0", vcyc_a, ferr_cnt_a, ovr_cnt_a); end
    send_frame(1'b0, 8, 8'h81, 1'b1, 1'b0, t0);
    cycles(20);
    n_cmp++; if (data_a !== 8'h81 || vcyc_a !== 1) begin n_bad++; $display("FAIL glitch_next: got d=%h vcyc=%0d want 81/1", data_a, vcyc_a); end
  endtask

  task automatic test_mid_reset();
    int t0;
    clear_mon();
    rx_a = 1'b0;
    cycles(8);
    rx_a = 1'b1;
    cycles(24);
    n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL mrst_in_frame: got busy=%b want 1", busy_a); end
    rst_n = 1'b0;
    cycles(2);
    n_cmp++; if (data_a !== 8'h00 || val_a !== 1'b0) begin n_bad++; $display("FAIL mrst_outputs: got d=%h v=%b want 00/0", data_a, val_a); end
    n_cmp++; if ({busy_a, ferr_a, ovr_a} !== 3'b000) begin n_bad++; $display("FAIL mrst_flags: got %b want 000", {busy_a, ferr_a, ovr_a}); end
    rst_n = 1'b1;
    cycles(60);
    n_cmp++; if (ferr_cnt_a !== 0 || ovr_cnt_a !== 0 || vcyc_a !== 0) begin n_bad++; $display("FAIL mrst_no_pulse: got ferr=%0d ovr=%0d vcyc=%0d want 0/0/0", ferr_cnt_a, ovr_cnt_a, vcyc_a); end
    send_frame(1'b0, 8, 8'h12, 1'b1, 1'b0, t0);
    cycles(20);
    n_cmp++; if (data_a !== 8'h12 || vcyc_a !== 1) begin n_bad++; $display("FAIL mrst_next: got d=%h vcyc=%0d want 12/1", data_a, vcyc_a); end
  endtask

  task automatic test_ready_on_delivery();
    int t0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    clear_mon();
    send_frame(1'b0, 8, 8'h11, 1'b1, 1'b0, t0);
    cycles(5);
    n_cmp++; if (val_a !== 1'b1 || data_a !== 8'h11) begin n_bad++; $display("FAIL rdy8_first: got v=%b d=%h want 1/11", val_a, data_a); end
    send_frame(1'b0, 8, 8'h22, 1'b1, 1'b1, t0);
    cycles(3);
    n_cmp++; if (val_a !== 1'b1 || data_a !== 8'h22) begin n_bad++; $display("FAIL rdy8_reload: got v=%b d=%h want 1/22", val_a, data_a); end
    n_cmp++; if (ovr_cnt_a !== 0 || fall_a !== 0) begin n_bad++; $display("FAIL rdy8_no_ovr: got ovr=%0d fall=%0d want 0/0", ovr_cnt_a, fall_a); end
    rdy_a = 1'b1;
    cycles(1);
    rdy_a = 1'b0;
    n_cmp++; if (val_a !== 1'b0 || data_a !== 8'h22) begin n_bad++; $display("FAIL rdy8_accept: got v=%b d=%h want 0/22", val_a, data_a); end

    send_frame(1'b1, 5, 8'h11, 1'b1, 1'b0, t0);
    cycles(5);
    n_cmp++; if (val_b !== 1'b1 || data_b !== 8'h11) begin n_bad++; $display("FAIL rdy5_first: got v=%b d=%h want 1/11", val_b, data_b); end
    send_frame(1'b1, 5, 8'h6B, 1'b1, 1'b1, t0);
    cycles(3);
    n_cmp++; if (val_b !== 1'b1 || data_b !== 8'h6B) begin n_bad++; $display("FAIL rdy5_reload: got v=%b d=%h want 1/6b", val_b, data_b); end
    n_cmp++; if (ovr_cnt_b !== 0 || fall_b !== 0 || ferr_cnt_b !== 0) begin n_bad++; $display("FAIL rdy5_no_err: got ovr=%0d fall=%0d ferr=%0d want 0/0/0", ovr_cnt_b, fall_b, ferr_cnt_b); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    both_cnt = 0;
    clear_mon();
    test_reset();
    test_basic();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_mid_reset();
    test_ready_on_delivery();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL err_exclusive: got %0d overlapping cycles want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receive stage that feeds the board top's UART_RX input path.
- Converts the asynchronous 8N1 serial line into bytes, presented on a valid/ready handshake to the downstream consumer (LED/command logic in the top level).
- Single clock domain.
- Fixed-ratio baud timing, mid-bit sampling, framing and overrun detection.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per serial bit (12 MHz / 115200); legal range 4..65535.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.

Ports:
- clock  input  1  system clock
- i_reset_n  input  1  reset
- i_rx  input  1  asynchronous serial line, idle high
- o_data  output  DATA_BITS  received byte, valid while o_valid=1
- o_valid  output  1  byte available
- i_ready  input  1  consumer accepts byte when o_valid&&i_ready at a rising edge
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low
- o_overrun  output  1  one-cycle pulse: completed byte dropped because holding register still full
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: i_reset_n synchronous, active-low, on clock rising edge. While low:
  - state=IDLE, all counters 0.
  - Synchroniser flops =1.
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
- Reset asserted mid-frame aborts the frame with no error pulse.
- Input synchroniser: i_rx passes through 2 flops (rx_s). All decisions use rx_s only.
- Constants: HALF=CLKS_PER_BIT/2 (integer division). Baud counter width is $clog2(CLKS_PER_BIT).
- IDLE: when rx_s=0 -> START, cnt=0.
- START: increment cnt. When cnt==HALF-1, sample rx_s:
  - rx_s=0 -> DATA, cnt=0, bit_idx=0.
  - rx_s=1 -> false start (glitch), return to IDLE with no pulse.
- DATA: increment cnt. When cnt==CLKS_PER_BIT-1:
  - Shift rx_s into shift register MSB (LSB-first reception), cnt=0.
  - When bit_idx==DATA_BITS-1 -> STOP; otherwise bit_idx+1.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 -> deliver (see holding register), then IDLE.
  - rx_s=0 -> o_frame_err=1 for one cycle, byte discarded, then BREAK.
- BREAK: remain until rx_s=1, then IDLE. A held-low line yields exactly one frame_err.
- Latency: let t0 be the edge at which the first 0 on i_rx is captured by sync flop 1.
  - Data bit k is sampled at edge t0+2+HALF+(k+1)*CLKS_PER_BIT.
  - o_valid is first high in the cycle after edge t0+2+HALF+(DATA_BITS+1)*CLKS_PER_BIT.
- Holding register (o_data/o_valid) on delivery:
  - o_valid=0 -> load o_data, o_valid<=1.
  - o_valid=1 and i_ready=1 in the same cycle -> load new byte, o_valid stays 1. Counts as accept plus load; no overrun.
  - o_valid=1 and i_ready=0 -> new byte dropped, old byte retained, o_overrun=1 for one cycle.
- Without delivery: o_valid&&i_ready -> o_valid<=0, o_data holds its last value.
- o_data and o_valid must not change while o_valid=1 and i_ready=0, except as defined above (retained).
- i_ready is ignored when o_valid=0.
- Back-to-back frames: the start bit may follow the stop-bit sample immediately. IDLE is entered on the stop-sample edge, so a new falling edge is detected within the stop bit's second half.
- o_frame_err and o_overrun are never both high in the same cycle.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [2:0] rx_state_t {IDLE, START, DATA, STOP, BREAK}.
  - Default-constant localparams: DEF_CLKS_PER_BIT=104, DEF_DATA_BITS=8.
- Sub-module sync_2ff:
  - Parameter RESET_VAL.
  - Two-flop synchroniser with synchronous active-low reset.
  - Reused later for other asynchronous pins (buttons, future VSync/HSync inputs).
- Baud counter, bit counter and holding register stay inline in uart_rx.

Test Plan (CLKS_PER_BIT=8, DATA_BITS=8 unless stated):
1. Reset then send 0xA5 (8N1, 8 clocks/bit), i_ready=1 -> o_valid high exactly 1 cycle in the cycle after edge t0+2+4+72, o_data=0xA5, no error pulses.
2. Send 0x3C then 0xC3 back-to-back with i_ready=0, then raise i_ready -> 0x3C held; o_overrun pulses once at the second stop sample; after handshake o_valid=0 and o_data stays 0x3C.
3. Send 0x55 with stop bit forced 0, line released high 20 clocks later -> one o_frame_err pulse, o_valid stays 0, o_busy high until line high, then 0x0F is received correctly.
4. 2-clock low glitch on idle line -> returns to IDLE at start sample, no o_valid, no errors; a following 0x81 frame is received correctly.
5. Reset asserted mid-DATA of 0xFF, released, then 0x12 sent -> outputs 0 during reset, no error pulse, 0x12 delivered.
6. o_valid=1 with 0x11 while 0x22 completes and i_ready=1 in the stop-sample cycle -> o_valid remains 1, o_data=0x22, no o_overrun; repeat with CLKS_PER_BIT=5 (odd, HALF=2) for 0x6B.
